// File: rtl/gemm_tile_scheduler.sv
// Tile command sequencer for one GEMM job: walks (mi,ni,ki) with running address
// offsets, tracks outstanding C write-backs and reports busy/done/error/cycle count.
module gemm_tile_scheduler #(
  parameter int TILE       = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DIM_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  matrix_m,
  input  logic [DIM_WIDTH-1:0]  matrix_n,
  input  logic [DIM_WIDTH-1:0]  matrix_k,
  input  logic [1:0]            data_format,
  input  logic                  accumulate_mode,
  input  logic [ADDR_WIDTH-1:0] addr_a_base,
  input  logic [ADDR_WIDTH-1:0] addr_b_base,
  input  logic [ADDR_WIDTH-1:0] addr_c_base,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_a_addr,
  output logic [ADDR_WIDTH-1:0] cmd_b_addr,
  output logic [ADDR_WIDTH-1:0] cmd_c_addr,
  output logic [DIM_WIDTH-1:0]  cmd_rows,
  output logic [DIM_WIDTH-1:0]  cmd_cols,
  output logic [DIM_WIDTH-1:0]  cmd_depth,
  output logic                  cmd_first_k,
  output logic                  cmd_load_c,
  output logic                  cmd_last_k,
  input  logic                  wb_done,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           cycles_counter
);
  localparam int TSH = $clog2(TILE);
  localparam int OW  = 2 * DIM_WIDTH + 1;
  localparam logic [DIM_WIDTH-1:0]  TILE_D = DIM_WIDTH'(TILE);
  localparam logic [ADDR_WIDTH-1:0] C_STEP = ADDR_WIDTH'(TILE * 4);

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_ISSUE, S_DRAIN, S_FIN} state_t;

  state_t                state_q, state_d;
  logic [DIM_WIDTH-1:0]  m_q, m_d, n_q, n_d, k_q, k_d;
  logic [1:0]            esz_q, esz_d;
  logic                  acc_q, acc_d;
  logic [ADDR_WIDTH-1:0] base_a_q, base_a_d, base_b_q, base_b_d, base_c_q, base_c_d;
  // rem_* hold the remaining extent (dim - idx*TILE), which replaces idx multiplies
  logic [DIM_WIDTH-1:0]  rem_m_q, rem_m_d, rem_n_q, rem_n_d, rem_k_q, rem_k_d;
  logic [ADDR_WIDTH-1:0] a_row_q, a_row_d, a_q, a_d;
  logic [ADDR_WIDTH-1:0] b_col_q, b_col_d, b_q, b_d;
  logic [ADDR_WIDTH-1:0] c_row_q, c_row_d, c_q, c_d;
  logic [OW-1:0]         outst_q, outst_d;
  logic                  busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [31:0]           cyc_q, cyc_d;

  logic                  hs, last_m, last_n, last_k, inc, dec;
  logic [ADDR_WIDTH-1:0] esz_step, stride_a, stride_b, stride_c;

  assign esz_step = ADDR_WIDTH'(TILE) << esz_q;
  assign stride_a = (ADDR_WIDTH'(k_q) << TSH) << esz_q;
  assign stride_b = (ADDR_WIDTH'(n_q) << TSH) << esz_q;
  assign stride_c = ADDR_WIDTH'(n_q) << (TSH + 2);

  assign last_m = (rem_m_q <= TILE_D);
  assign last_n = (rem_n_q <= TILE_D);
  assign last_k = (rem_k_q <= TILE_D);

  assign cmd_valid   = (state_q == S_ISSUE);
  assign hs          = cmd_valid & cmd_ready;
  assign cmd_a_addr  = a_q;
  assign cmd_b_addr  = b_q;
  assign cmd_c_addr  = c_q;
  assign cmd_rows    = last_m ? rem_m_q : TILE_D;
  assign cmd_cols    = last_n ? rem_n_q : TILE_D;
  assign cmd_depth   = last_k ? rem_k_q : TILE_D;
  assign cmd_first_k = cmd_valid & (rem_k_q == k_q);
  assign cmd_load_c  = cmd_first_k & acc_q;
  assign cmd_last_k  = cmd_valid & last_k;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign cycles_counter = cyc_q;

  assign inc = hs & last_k;
  // a write-back with nothing outstanding is spurious unless it pairs with this handshake
  assign dec = wb_done & ((outst_q != '0) | inc);

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;      n_d      = n_q;      k_d      = k_q;
    esz_d    = esz_q;    acc_d    = acc_q;
    base_a_d = base_a_q; base_b_d = base_b_q; base_c_d = base_c_q;
    rem_m_d  = rem_m_q;  rem_n_d  = rem_n_q;  rem_k_d  = rem_k_q;
    a_row_d  = a_row_q;  a_d      = a_q;
    b_col_d  = b_col_q;  b_d      = b_q;
    c_row_d  = c_row_q;  c_d      = c_q;
    busy_d   = busy_q;   done_d   = done_q;   error_d  = error_q;
    cyc_d    = (busy_q && cyc_q != 32'hFFFF_FFFF) ? cyc_q + 32'd1 : cyc_q;
    outst_d  = outst_q;
    case ({inc, dec})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LATCH;
          m_d      = matrix_m;
          n_d      = matrix_n;
          k_d      = matrix_k;
          acc_d    = accumulate_mode;
          base_a_d = addr_a_base;
          base_b_d = addr_b_base;
          base_c_d = addr_c_base;
          case (data_format)
            2'b00:   esz_d = 2'd0;
            2'b11:   esz_d = 2'd2;
            default: esz_d = 2'd1;
          endcase
          busy_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
          cyc_d   = '0;
        end
      end
      S_LATCH: begin
        rem_m_d = m_q;      rem_n_d = n_q;      rem_k_d = k_q;
        a_row_d = base_a_q; a_d     = base_a_q;
        b_col_d = base_b_q; b_d     = base_b_q;
        c_row_d = base_c_q; c_d     = base_c_q;
        if (m_q == '0 || n_q == '0 || k_q == '0) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (hs) begin
          if (!last_k) begin
            rem_k_d = rem_k_q - TILE_D;
            a_d     = a_q + esz_step;
            b_d     = b_q + stride_b;
          end else begin
            rem_k_d = k_q;
            if (!last_n) begin
              rem_n_d = rem_n_q - TILE_D;
              a_d     = a_row_q;
              b_col_d = b_col_q + esz_step;
              b_d     = b_col_q + esz_step;
              c_d     = c_q + C_STEP;
            end else begin
              rem_n_d = n_q;
              b_col_d = base_b_q;
              b_d     = base_b_q;
              if (!last_m) begin
                rem_m_d = rem_m_q - TILE_D;
                a_row_d = a_row_q + stride_a;
                a_d     = a_row_q + stride_a;
                c_row_d = c_row_q + stride_c;
                c_d     = c_row_q + stride_c;
              end else begin
                state_d = S_DRAIN;
              end
            end
          end
        end
      end
      S_DRAIN: begin
        if (outst_q == '0) state_d = S_FIN;
      end
      S_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      m_q      <= '0; n_q      <= '0; k_q      <= '0;
      esz_q    <= '0; acc_q    <= 1'b0;
      base_a_q <= '0; base_b_q <= '0; base_c_q <= '0;
      rem_m_q  <= '0; rem_n_q  <= '0; rem_k_q  <= '0;
      a_row_q  <= '0; a_q      <= '0;
      b_col_q  <= '0; b_q      <= '0;
      c_row_q  <= '0; c_q      <= '0;
      outst_q  <= '0;
      busy_q   <= 1'b0; done_q <= 1'b0; error_q <= 1'b0;
      cyc_q    <= '0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;      n_q      <= n_d;      k_q      <= k_d;
      esz_q    <= esz_d;    acc_q    <= acc_d;
      base_a_q <= base_a_d; base_b_q <= base_b_d; base_c_q <= base_c_d;
      rem_m_q  <= rem_m_d;  rem_n_q  <= rem_n_d;  rem_k_q  <= rem_k_d;
      a_row_q  <= a_row_d;  a_q      <= a_d;
      b_col_q  <= b_col_d;  b_q      <= b_d;
      c_row_q  <= c_row_d;  c_q      <= c_d;
      outst_q  <= outst_d;
      busy_q   <= busy_d;   done_q   <= done_d;   error_q  <= error_d;
      cyc_q    <= cyc_d;
    end
  end
endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Directed bench for gemm_tile_scheduler: collects accepted commands, answers each
// last_k command with a wb_done pulse on the following cycle, checks against hand values.
module tb_gemm_tile_scheduler;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] matrix_m, matrix_n, matrix_k;
  logic [1:0]  data_format;
  logic        accumulate_mode;
  logic [31:0] addr_a_base, addr_b_base, addr_c_base;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_a_addr, cmd_b_addr, cmd_c_addr;
  logic [15:0] cmd_rows, cmd_cols, cmd_depth;
  logic        cmd_first_k, cmd_load_c, cmd_last_k;
  logic        wb_done;
  logic        busy, done, error;
  logic [31:0] cycles_counter;

  int checks = 0;
  int passed = 0;

  logic [31:0] ra [64];
  logic [31:0] rb [64];
  logic [31:0] rc [64];
  logic [15:0] rr [64];
  logic [2:0]  rf [64];
  int          n_cmd = 0;
  int          owed  = 0;

  always #5 clk = ~clk;

  gemm_tile_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .matrix_m(matrix_m), .matrix_n(matrix_n), .matrix_k(matrix_k),
    .data_format(data_format), .accumulate_mode(accumulate_mode),
    .addr_a_base(addr_a_base), .addr_b_base(addr_b_base), .addr_c_base(addr_c_base),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a_addr(cmd_a_addr), .cmd_b_addr(cmd_b_addr), .cmd_c_addr(cmd_c_addr),
    .cmd_rows(cmd_rows), .cmd_cols(cmd_cols), .cmd_depth(cmd_depth),
    .cmd_first_k(cmd_first_k), .cmd_load_c(cmd_load_c), .cmd_last_k(cmd_last_k),
    .wb_done(wb_done), .busy(busy), .done(done), .error(error),
    .cycles_counter(cycles_counter)
  );

  // Command collector and write-back responder share one process.
  initial begin
    wb_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        owed = 0;
      end else if (cmd_valid && cmd_ready) begin
        if (n_cmd < 64) begin
          ra[n_cmd] = cmd_a_addr;
          rb[n_cmd] = cmd_b_addr;
          rc[n_cmd] = cmd_c_addr;
          rr[n_cmd] = cmd_rows;
          rf[n_cmd] = {cmd_first_k, cmd_load_c, cmd_last_k};
        end
        n_cmd++;
        if (cmd_last_k) owed++;
      end
      @(posedge clk); #1;
      if (rst_n && owed > 0) begin
        wb_done = 1'b1;
        owed--;
      end else begin
        wb_done = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_job(input logic [15:0] m, input logic [15:0] n, input logic [15:0] k,
                           input logic [1:0] fmt, input logic acc);
    matrix_m = m; matrix_n = n; matrix_k = k;
    data_format = fmt; accumulate_mode = acc;
    addr_a_base = 32'h1000; addr_b_base = 32'h2000; addr_c_base = 32'h3000;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; cmd_ready = 1'b1;
    matrix_m = '0; matrix_n = '0; matrix_k = '0; data_format = '0; accumulate_mode = 1'b0;
    addr_a_base = '0; addr_b_base = '0; addr_c_base = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_valid, busy, done, error, cmd_first_k, cmd_load_c, cmd_last_k} !== 7'b0 ||
        cycles_counter !== 32'd0 || cmd_a_addr !== 32'd0 || cmd_rows !== 16'd0)
      $display("FAIL reset_state: valid=%b busy=%b done=%b err=%b cyc=%0d a=%h rows=%0d expected all 0",
               cmd_valid, busy, done, error, cycles_counter, cmd_a_addr, cmd_rows);
    else passed++;
    tick();
  endtask

  task automatic test_single_tile();
    bit ok;
    int b0 = n_cmd;
    start_job(16, 16, 16, 2'b10, 1'b0);
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL single_latch: valid=%b busy=%b expected valid=0 busy=1", cmd_valid, busy);
    else passed++;
    tick();
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_a_addr !== 32'h1000 || cmd_b_addr !== 32'h2000 ||
        cmd_c_addr !== 32'h3000 || cmd_rows !== 16'd16 || cmd_cols !== 16'd16 ||
        cmd_depth !== 16'd16 || {cmd_first_k, cmd_load_c, cmd_last_k} !== 3'b101)
      $display("FAIL single_cmd: valid=%b a=%h b=%h c=%h r/c/d=%0d/%0d/%0d flags=%b expected 1 1000 2000 3000 16/16/16 101",
               cmd_valid, cmd_a_addr, cmd_b_addr, cmd_c_addr, cmd_rows, cmd_cols, cmd_depth,
               {cmd_first_k, cmd_load_c, cmd_last_k});
    else passed++;
    tick();
    wait_done(ok);
    checks++;
    if (!ok || busy !== 1'b0 || error !== 1'b0 || (n_cmd - b0) != 1 || cycles_counter !== 32'd5)
      $display("FAIL single_done: done_seen=%0d busy=%b err=%b cmds=%0d cyc=%0d expected 1 0 0 1 5",
               ok, busy, error, n_cmd - b0, cycles_counter);
    else passed++;
  endtask

  task automatic check_four(input int b0, input string name);
    logic [31:0] ea [4];
    logic [31:0] eb [4];
    logic [31:0] ec [4];
    logic [2:0]  ef [4];
    ea = '{32'h1000, 32'h1020, 32'h1400, 32'h1420};
    eb = '{32'h2000, 32'h2200, 32'h2000, 32'h2200};
    ec = '{32'h3000, 32'h3000, 32'h3400, 32'h3400};
    ef = '{3'b100, 3'b001, 3'b100, 3'b001};
    checks++;
    if ((n_cmd - b0) != 4) $display("FAIL %s_count: got %0d expected 4", name, n_cmd - b0);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ra[b0+i] !== ea[i] || rb[b0+i] !== eb[i] || rc[b0+i] !== ec[i] ||
          rf[b0+i] !== ef[i] || rr[b0+i] !== 16'd16)
        $display("FAIL %s_cmd%0d: a=%h b=%h c=%h flags=%b rows=%0d expected %h %h %h %b 16",
                 name, i, ra[b0+i], rb[b0+i], rc[b0+i], rf[b0+i], rr[b0+i], ea[i], eb[i], ec[i], ef[i]);
      else passed++;
    end
  endtask

  task automatic test_multi_tile();
    bit ok;
    int b0 = n_cmd;
    start_job(32, 16, 32, 2'b10, 1'b0);
    wait_done(ok);
    check_four(b0, "multi");
    checks++;
    if (!ok || cycles_counter !== 32'd8)
      $display("FAIL multi_cycles: done_seen=%0d cyc=%0d expected 1 8", ok, cycles_counter);
    else passed++;
  endtask

  task automatic test_partial_accumulate();
    bit ok;
    int b0 = n_cmd;
    start_job(20, 16, 16, 2'b10, 1'b1);
    wait_done(ok);
    checks++;
    if ((n_cmd - b0) != 2 || rr[b0] !== 16'd16 || rr[b0+1] !== 16'd4)
      $display("FAIL partial_rows: cmds=%0d rows=%0d,%0d expected 2 16,4", n_cmd - b0, rr[b0], rr[b0+1]);
    else passed++;
    checks++;
    if (rf[b0] !== 3'b111 || rf[b0+1] !== 3'b111)
      $display("FAIL partial_flags: %b,%b expected 111,111", rf[b0], rf[b0+1]);
    else passed++;
    checks++;
    if (ra[b0+1] !== 32'h1200 || rb[b0+1] !== 32'h2000 || rc[b0+1] !== 32'h3400)
      $display("FAIL partial_addr: a=%h b=%h c=%h expected 1200 2000 3400", ra[b0+1], rb[b0+1], rc[b0+1]);
    else passed++;
    // second command's last_k handshake coincides with the first wb_done
    checks++;
    if (!ok || cycles_counter !== 32'd6)
      $display("FAIL coincide_wb: done_seen=%0d cyc=%0d expected 1 6", ok, cycles_counter);
    else passed++;
  endtask

  task automatic test_stall_and_restart();
    bit ok;
    int stable_bad = 0;
    int b0 = n_cmd;
    cmd_ready = 1'b0;
    start_job(32, 16, 32, 2'b10, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cmd_valid !== 1'b1 || cmd_a_addr !== 32'h1000 || cmd_b_addr !== 32'h2000 ||
          cmd_c_addr !== 32'h3000 || cmd_depth !== 16'd16 || cmd_first_k !== 1'b1)
        stable_bad++;
      tick();
      if (i == 0) begin
        start = 1'b1; matrix_m = 16'd16; matrix_k = 16'd0; addr_a_base = 32'hDEAD_0000;
      end
      if (i == 1) start = 1'b0;
    end
    cmd_ready = 1'b1;
    checks++;
    if (stable_bad != 0) $display("FAIL stall_stable: %0d unstable cycles expected 0", stable_bad);
    else passed++;
    wait_done(ok);
    check_four(b0, "stall");
    checks++;
    if (!ok || cycles_counter !== 32'd13 || error !== 1'b0)
      $display("FAIL stall_cycles: done_seen=%0d cyc=%0d err=%b expected 1 13 0", ok, cycles_counter, error);
    else passed++;
  endtask

  task automatic test_zero_dim();
    bit ok;
    int b0 = n_cmd;
    start_job(16, 16, 0, 2'b00, 1'b0);
    tick();
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b1 || cmd_valid !== 1'b0)
      $display("FAIL zero_fin: err=%b done=%b busy=%b valid=%b expected 1 0 1 0", error, done, busy, cmd_valid);
    else passed++;
    tick();
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || cycles_counter !== 32'd2 || n_cmd != b0)
      $display("FAIL zero_done: err=%b done=%b busy=%b cyc=%0d cmds=%0d expected 1 1 0 2 0",
               error, done, busy, cycles_counter, n_cmd - b0);
    else passed++;
    tick();
    start_job(16, 16, 16, 2'b11, 1'b0);
    @(negedge clk);
    checks++;
    if (error !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || cycles_counter !== 32'd0)
      $display("FAIL zero_clear: err=%b done=%b busy=%b cyc=%0d expected 0 0 1 0", error, done, busy, cycles_counter);
    else passed++;
    tick();
    wait_done(ok);
    checks++;
    if (!ok || error !== 1'b0 || (n_cmd - b0) != 1)
      $display("FAIL zero_next_job: done_seen=%0d err=%b cmds=%0d expected 1 0 1", ok, error, n_cmd - b0);
    else passed++;
  endtask

  task automatic test_reset_mid_issue();
    cmd_ready = 1'b0;
    start_job(32, 16, 32, 2'b10, 1'b1);
    tick();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_valid, busy, done, error, cmd_first_k, cmd_load_c, cmd_last_k} !== 7'b0 ||
        cycles_counter !== 32'd0 || cmd_a_addr !== 32'd0 || cmd_b_addr !== 32'd0 ||
        cmd_c_addr !== 32'd0 || cmd_rows !== 16'd0 || cmd_cols !== 16'd0 || cmd_depth !== 16'd0)
      $display("FAIL reset_mid: valid=%b busy=%b cyc=%0d a=%h b=%h c=%h r/c/d=%0d/%0d/%0d expected all 0",
               cmd_valid, busy, cycles_counter, cmd_a_addr, cmd_b_addr, cmd_c_addr, cmd_rows, cmd_cols, cmd_depth);
    else passed++;
    @(posedge clk); #1 rst_n = 1'b1;
    cmd_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_release: valid=%b busy=%b expected 0 0", cmd_valid, busy);
    else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_partial_accumulate();
    test_stall_and_restart();
    test_zero_dim();
    test_reset_mid_issue();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
